// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity modes, FSM states
// and a counter-width helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int ctrWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the queued UART transmitter: write strobe, data,
// flow control and line/status outputs.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);

  logic                              i_txDV;
  logic [DATA_BITS-1:0]              i_txData;
  logic                              o_txReady;
  logic                              o_txSerial;
  logic                              o_txBusy;
  logic                              o_txDone;
  logic [ctrWidth(FIFO_DEPTH):0]     o_fifoCount;

  modport master (
    output i_txDV, i_txData,
    input  o_txReady, o_txSerial, o_txBusy, o_txDone, o_fifoCount
  );

  modport slave (
    input  i_txDV, i_txData,
    output o_txReady, o_txSerial, o_txBusy, o_txDone, o_fifoCount
  );

endinterface

// File: rtl/uart_fifo.sv
// Single-clock show-ahead FIFO; rdData always presents the oldest word.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = ctrWidth(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_resetN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_COUNT);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // Pointers wrap naturally; the extra count bit separates full from empty.
  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter with configurable data bits, parity and stop bits;
// frames held in the FIFO go out back-to-back with no idle bit between them.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic           i_clock,
  input  logic           i_resetN,
  uart_tx_fifo_if.slave  bus
);

  localparam int BCW = ctrWidth(CLOCKS_PER_BIT);
  localparam int ICW = ctrWidth(DATA_BITS);
  localparam int SCW = ctrWidth(STOP_BITS);
  localparam int FCW = ctrWidth(FIFO_DEPTH) + 1;
  localparam logic [BCW-1:0] BIT_LAST    = BCW'(CLOCKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BIT_PRELAST = BCW'(CLOCKS_PER_BIT - 2);
  localparam logic [ICW-1:0] IDX_LAST    = ICW'(DATA_BITS - 1);
  localparam logic [SCW-1:0] STOP_LAST   = SCW'(STOP_BITS - 1);

  txState_t             state;
  logic [BCW-1:0]       bitCnt;
  logic [ICW-1:0]       bitIdx;
  logic [SCW-1:0]       stopIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityAcc;
  logic [DATA_BITS-1:0] fifoData;
  logic [FCW-1:0]       fifoCount;
  logic [FCW-1:0]       countNext;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 push;
  logic                 pop;
  logic                 bitEnd;
  logic                 frameEnd;
  logic                 goIdle;

  function automatic logic parityBit(input logic dataXor);
    return (PARITY == PARITY_ODD) ? ~dataXor : dataXor;
  endfunction

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .i_clock  (i_clock),
    .i_resetN (i_resetN),
    .push     (bus.i_txDV),
    .pop      (pop),
    .wrData   (bus.i_txData),
    .rdData   (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign push     = bus.i_txDV && !fifoFull;
  assign bitEnd   = (bitCnt == BIT_LAST);
  assign frameEnd = (state == ST_STOP) && bitEnd && (stopIdx == STOP_LAST);
  assign pop      = !fifoEmpty && ((state == ST_IDLE) || frameEnd);
  assign goIdle   = fifoEmpty && ((state == ST_IDLE) || frameEnd);
  assign countNext = fifoCount + FCW'(push) - FCW'(pop);

  assign bus.o_txReady   = !fifoFull;
  assign bus.o_fifoCount = fifoCount;

  always_ff @(posedge i_clock) begin
    if (!i_resetN) begin
      state          <= ST_IDLE;
      bitCnt         <= '0;
      bitIdx         <= '0;
      stopIdx        <= '0;
      bus.o_txSerial <= 1'b1;
      bus.o_txBusy   <= 1'b0;
      bus.o_txDone   <= 1'b0;
    end else begin
      bus.o_txBusy <= !(goIdle && (countNext == '0));
      // Registered pulse: raised one cycle early so it lands on the last stop clock.
      bus.o_txDone <= (state == ST_STOP) && (stopIdx == STOP_LAST) && (bitCnt == BIT_PRELAST);
      bitCnt       <= bitEnd ? '0 : bitCnt + 1'b1;
      unique case (state)
        ST_IDLE: begin
          bitCnt <= '0;
          if (pop) begin
            state          <= ST_START;
            bus.o_txSerial <= 1'b0;
          end
        end
        ST_START: if (bitEnd) begin
          state          <= ST_DATA;
          bitIdx         <= '0;
          bus.o_txSerial <= shiftReg[0];
        end
        ST_DATA: if (bitEnd) begin
          if (bitIdx == IDX_LAST) begin
            if (PARITY != PARITY_NONE) begin
              state          <= ST_PARITY;
              bus.o_txSerial <= parityBit(parityAcc ^ shiftReg[0]);
            end else begin
              state          <= ST_STOP;
              stopIdx        <= '0;
              bus.o_txSerial <= 1'b1;
            end
          end else begin
            bitIdx         <= bitIdx + 1'b1;
            bus.o_txSerial <= shiftReg[1];
          end
        end
        ST_PARITY: if (bitEnd) begin
          state          <= ST_STOP;
          stopIdx        <= '0;
          bus.o_txSerial <= 1'b1;
        end
        ST_STOP: if (bitEnd) begin
          if (stopIdx == STOP_LAST) begin
            if (pop) begin
              state          <= ST_START;
              bus.o_txSerial <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            stopIdx <= stopIdx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift register and running parity carry data only, so they are not reset.
  always_ff @(posedge i_clock) begin
    if (pop) begin
      shiftReg  <= fifoData;
      parityAcc <= 1'b0;
    end else if ((state == ST_DATA) && bitEnd) begin
      shiftReg  <= shiftReg >> 1;
      parityAcc <= parityAcc ^ shiftReg[0];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats side by side, a waveform-level
// reference model of the serial line, and directed scenarios with literal pins.
module tb_uart_tx_fifo;

  localparam int NI    = 4;
  localparam int DEPTH = 4;
  localparam int QLEN  = 512;
  localparam int CPB [NI] = '{4, 4, 4, 2};
  localparam int NB  [NI] = '{8, 8, 8, 5};
  localparam int PAR [NI] = '{0, 2, 1, 0};
  localparam int STP [NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       dv  [NI];
  logic [8:0] din [NI];
  logic       ser [NI];
  logic       dn  [NI];
  logic       bsy [NI];
  logic       rdy [NI];
  logic [2:0] cnt [NI];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus1 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus2 ();
  uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) bus3 ();

  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.i_clock(clk), .i_resetN(rstN), .bus(bus0));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut1 (.i_clock(clk), .i_resetN(rstN), .bus(bus1));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.i_clock(clk), .i_resetN(rstN), .bus(bus2));
  uart_tx_fifo #(.CLOCKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut3 (.i_clock(clk), .i_resetN(rstN), .bus(bus3));

  assign bus0.i_txDV = dv[0]; assign bus0.i_txData = din[0][7:0];
  assign bus1.i_txDV = dv[1]; assign bus1.i_txData = din[1][7:0];
  assign bus2.i_txDV = dv[2]; assign bus2.i_txData = din[2][7:0];
  assign bus3.i_txDV = dv[3]; assign bus3.i_txData = din[3][4:0];

  assign ser[0] = bus0.o_txSerial; assign dn[0] = bus0.o_txDone; assign bsy[0] = bus0.o_txBusy;
  assign rdy[0] = bus0.o_txReady;  assign cnt[0] = bus0.o_fifoCount;
  assign ser[1] = bus1.o_txSerial; assign dn[1] = bus1.o_txDone; assign bsy[1] = bus1.o_txBusy;
  assign rdy[1] = bus1.o_txReady;  assign cnt[1] = bus1.o_fifoCount;
  assign ser[2] = bus2.o_txSerial; assign dn[2] = bus2.o_txDone; assign bsy[2] = bus2.o_txBusy;
  assign rdy[2] = bus2.o_txReady;  assign cnt[2] = bus2.o_fifoCount;
  assign ser[3] = bus3.o_txSerial; assign dn[3] = bus3.o_txDone; assign bsy[3] = bus3.o_txBusy;
  assign rdy[3] = bus3.o_txReady;  assign cnt[3] = bus3.o_fifoCount;

  // Reference model: per-clock expected line entries {startOfFrame, done, line}.
  logic [2:0] lineBuf [NI][QLEN];
  int head [NI];
  int tail [NI];
  int mCount [NI];

  function automatic int qsz(input int k);
    return tail[k] - head[k];
  endfunction

  task automatic pushEntry(input int k, input logic [2:0] e);
    lineBuf[k][tail[k] % QLEN] = e;
    tail[k] = tail[k] + 1;
  endtask

  task automatic appendFrame(input int k, input logic [8:0] d);
    logic bits [16];
    int   n;
    logic p;
    p = 1'b0;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < NB[k]; i++) begin
      bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (PAR[k] == 2) begin bits[n] = p; n++; end
    else if (PAR[k] == 1) begin bits[n] = ~p; n++; end
    for (int i = 0; i < STP[k]; i++) begin bits[n] = 1'b1; n++; end
    for (int j = 0; j < n; j++)
      for (int c = 0; c < CPB[k]; c++)
        pushEntry(k, {(j == 0 && c == 0), (j == n - 1 && c == CPB[k] - 1), bits[j]});
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rstN) begin
        head[k] = 0;
        tail[k] = 0;
        mCount[k] = 0;
      end else begin
        if (qsz(k) > 0) head[k] = head[k] + 1;
        if (dv[k] && mCount[k] < DEPTH) begin
          if (qsz(k) == 0) pushEntry(k, 3'b001);
          appendFrame(k, din[k]);
          mCount[k] = mCount[k] + 1;
        end
        if (qsz(k) > 0 && lineBuf[k][head[k] % QLEN][2]) mCount[k] = mCount[k] - 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < NI; k++) begin
      logic [2:0] e;
      e = (qsz(k) > 0) ? lineBuf[k][head[k] % QLEN] : 3'b001;
      check($sformatf("i%0d serial", k), 32'(ser[k]), 32'(e[0]));
      check($sformatf("i%0d done", k), 32'(dn[k]), 32'(e[1]));
      check($sformatf("i%0d busy", k), 32'(bsy[k]), 32'((qsz(k) > 0) || (mCount[k] != 0)));
      check($sformatf("i%0d count", k), 32'(cnt[k]), 32'(mCount[k]));
      check($sformatf("i%0d ready", k), 32'(rdy[k]), 32'(mCount[k] < DEPTH));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compareAll();
  endtask

  logic samp  [64];
  logic dsamp [64];

  task automatic writeWord(input int k, input logic [8:0] d);
    dv[k] = 1'b1;
    din[k] = d;
    tick();
    dv[k] = 1'b0;
  endtask

  task automatic capture(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      samp[i] = ser[k];
      dsamp[i] = dn[k];
    end
  endtask

  task automatic drain(input int k, input int bound, output int dones, output int lastDone,
                       output int fallAt);
    dones = 0;
    lastDone = -1;
    fallAt = -1;
    for (int n = 0; n < bound; n++) begin
      tick();
      if (dn[k] === 1'b1) begin
        dones++;
        lastDone = n;
      end
      if (bsy[k] === 1'b0) begin
        fallAt = n;
        break;
      end
    end
    check("drain within bound", 32'(fallAt >= 0), 32'd1);
  endtask

  initial begin
    logic basicExp [10];
    int ones, dones, lastDone, fallAt, n;
    basicExp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < NI; k++) begin dv[k] = 1'b0; din[k] = '0; end

    // Reset state
    repeat (3) tick();
    check("reset serial", 32'(ser[0]), 32'd1);
    check("reset busy", 32'(bsy[0]), 32'd0);
    check("reset done", 32'(dn[0]), 32'd0);
    check("reset count", 32'(cnt[0]), 32'd0);
    check("reset ready", 32'(rdy[0]), 32'd1);
    rstN = 1'b1;
    repeat (2) tick();

    // Basic 8N1 frame of 0xA5
    writeWord(0, 9'h0A5);
    check("basic idle before start", 32'(ser[0]), 32'd1);
    check("basic count at accept", 32'(cnt[0]), 32'd1);
    capture(0, 44);
    for (int j = 0; j < 10; j++)
      check($sformatf("basic bit %0d", j), 32'(samp[j * 4 + 3]), 32'(basicExp[j]));
    check("basic done at clock 40", 32'(dsamp[39]), 32'd1);
    dones = 0;
    for (int i = 0; i < 44; i++) dones += int'(dsamp[i]);
    check("basic done pulses", 32'(dones), 32'd1);

    // Parity frames
    writeWord(1, 9'h0A5);
    capture(1, 46);
    check("8E1 A5 parity", 32'(samp[36]), 32'd0);
    check("8E1 A5 done at 44", 32'(dsamp[43]), 32'd1);
    writeWord(2, 9'h007);
    capture(2, 46);
    check("8O1 07 parity", 32'(samp[36]), 32'd0);
    writeWord(1, 9'h007);
    capture(1, 46);
    check("8E1 07 parity", 32'(samp[36]), 32'd1);
    check("8E1 07 stop", 32'(samp[40]), 32'd1);

    // 5 data bits, 2 stop bits, 2 clocks per bit
    writeWord(3, 9'h01F);
    capture(3, 18);
    check("5N2 start", 32'(samp[1]), 32'd0);
    ones = 0;
    for (int i = 2; i < 16; i++) ones += int'(samp[i]);
    check("5N2 high clocks", 32'(ones), 32'd14);
    check("5N2 done at 16", 32'(dsamp[15]), 32'd1);
    check("5N2 done early", 32'(dsamp[13]), 32'd0);

    // Six writes on consecutive cycles into a depth-4 FIFO
    dv[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din[0] = 9'(8'h11 * (i + 1));
      tick();
      if (i == 4) begin
        check("full count", 32'(cnt[0]), 32'd4);
        check("full ready", 32'(rdy[0]), 32'd0);
      end
    end
    dv[0] = 1'b0;
    check("dropped write count", 32'(cnt[0]), 32'd4);
    drain(0, 400, dones, lastDone, fallAt);
    check("burst frames", 32'(dones), 32'd5);
    check("busy falls after last done", 32'(fallAt), 32'(lastDone + 1));

    // Push on the exact cycle a frame end pops the next word
    writeWord(0, 9'h03C);
    writeWord(0, 9'h0C3);
    check("concurrent count A", 32'(cnt[0]), 32'd1);
    n = 0;
    while (dn[0] !== 1'b1 && n < 100) begin tick(); n++; end
    check("done seen", 32'(n < 100), 32'd1);
    writeWord(0, 9'h05A);
    check("concurrent count B", 32'(cnt[0]), 32'd1);
    check("back-to-back start", 32'(ser[0]), 32'd0);
    drain(0, 200, dones, lastDone, fallAt);
    check("concurrent frames", 32'(dones), 32'd2);

    // Reset during data bit 3 of the second queued word
    writeWord(0, 9'h081);
    writeWord(0, 9'h0F7);
    repeat (57) tick();
    check("pre-reset data bit 3", 32'(ser[0]), 32'd0);
    rstN = 1'b0;
    tick();
    check("abort serial", 32'(ser[0]), 32'd1);
    check("abort busy", 32'(bsy[0]), 32'd0);
    check("abort count", 32'(cnt[0]), 32'd0);
    rstN = 1'b1;
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      ones += int'(ser[0]);
    end
    check("no residual frame", 32'(ones), 32'd60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
